// File: rtl/taus_urng_48_16_pkg.sv
// Shared widths, taus88 shift/mask constants and step/sanitise helpers for taus_urng_48_16.
package urng_pkg;

    localparam int U0_W   = 48;
    localparam int U1_W   = 16;
    localparam int TAUS_W = 32;

    localparam int unsigned C0_Q = 32'd13;
    localparam int unsigned C0_S = 32'd19;
    localparam int unsigned C0_K = 32'd12;
    localparam int unsigned C1_Q = 32'd2;
    localparam int unsigned C1_S = 32'd25;
    localparam int unsigned C1_K = 32'd4;
    localparam int unsigned C2_Q = 32'd3;
    localparam int unsigned C2_S = 32'd11;
    localparam int unsigned C2_K = 32'd17;

    localparam logic [TAUS_W-1:0] C0_MASK = 32'hFFFF_FFFE;
    localparam logic [TAUS_W-1:0] C1_MASK = 32'hFFFF_FFF8;
    localparam logic [TAUS_W-1:0] C2_MASK = 32'hFFFF_FFF0;

    // Forcing these bits keeps every component above its lock-up threshold.
    localparam logic [TAUS_W-1:0] C0_SAN = 32'h0000_0002;
    localparam logic [TAUS_W-1:0] C1_SAN = 32'h0000_0008;
    localparam logic [TAUS_W-1:0] C2_SAN = 32'h0000_0010;

    typedef enum logic [1:0] {
        COMP_0    = 2'd0,
        COMP_1    = 2'd1,
        COMP_2    = 2'd2,
        COMP_NONE = 2'd3
    } comp_sel_e;

    function automatic logic [TAUS_W-1:0] taus_step(
        input logic [TAUS_W-1:0] s,
        input int unsigned       q,
        input int unsigned       sh,
        input int unsigned       k,
        input logic [TAUS_W-1:0] mask
    );
        logic [TAUS_W-1:0] b;
        b = ((s << q) ^ s) >> sh;
        return ((s & mask) << k) ^ b;
    endfunction

    function automatic logic [TAUS_W-1:0] sanitise(
        input logic [TAUS_W-1:0] s,
        input logic [TAUS_W-1:0] san
    );
        return s | san;
    endfunction

endpackage

// File: rtl/taus_urng_48_16_core.sv
// taus88_core: one three-component Tausworthe generator with sanitised seed load.
module taus88_core
    import urng_pkg::*;
#(
    parameter logic [TAUS_W-1:0] SEED0 = 32'h0000_3039,
    parameter logic [TAUS_W-1:0] SEED1 = 32'h0001_E240,
    parameter logic [TAUS_W-1:0] SEED2 = 32'h0009_6B43
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_adv,
    input  logic              i_we,
    input  logic [1:0]        i_sel,
    input  logic [TAUS_W-1:0] i_data,
    output logic [TAUS_W-1:0] o_word
);

    logic [TAUS_W-1:0] r_s0;
    logic [TAUS_W-1:0] r_s1;
    logic [TAUS_W-1:0] r_s2;
    logic [TAUS_W-1:0] w_n0;
    logic [TAUS_W-1:0] w_n1;
    logic [TAUS_W-1:0] w_n2;

    assign w_n0   = taus_step(r_s0, C0_Q, C0_S, C0_K, C0_MASK);
    assign w_n1   = taus_step(r_s1, C1_Q, C1_S, C1_K, C1_MASK);
    assign w_n2   = taus_step(r_s2, C2_Q, C2_S, C2_K, C2_MASK);
    // The output word is taken from the next state, so it is ready in the same cycle as adv.
    assign o_word = w_n0 ^ w_n1 ^ w_n2;

    // State registers: seed load has priority over stepping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0 <= sanitise(SEED0, C0_SAN);
            r_s1 <= sanitise(SEED1, C1_SAN);
            r_s2 <= sanitise(SEED2, C2_SAN);
        end else if (i_we) begin
            case (comp_sel_e'(i_sel))
                COMP_0:  r_s0 <= sanitise(i_data, C0_SAN);
                COMP_1:  r_s1 <= sanitise(i_data, C1_SAN);
                COMP_2:  r_s2 <= sanitise(i_data, C2_SAN);
                default: r_s0 <= r_s0;
            endcase
        end else if (i_adv) begin
            r_s0 <= w_n0;
            r_s1 <= w_n1;
            r_s2 <= w_n2;
        end else begin
            r_s0 <= r_s0;
            r_s1 <= r_s1;
            r_s2 <= r_s2;
        end
    end

endmodule

// File: rtl/taus_urng_48_16.sv
// Dual taus88 uniform source: u0 (48b) for the log path, u1 (16b) for the trig path.
// Optional macro URNG_ZERO_GUARD_EN replaces an all-zero u0 with 48'h1.
module taus_urng_48_16
    import urng_pkg::*;
#(
    parameter logic [TAUS_W-1:0] SEED_A0 = 32'h0000_3039,
    parameter logic [TAUS_W-1:0] SEED_A1 = 32'h0001_E240,
    parameter logic [TAUS_W-1:0] SEED_A2 = 32'h0009_6B43,
    parameter logic [TAUS_W-1:0] SEED_B0 = 32'h1234_5678,
    parameter logic [TAUS_W-1:0] SEED_B1 = 32'h9ABC_DEF0,
    parameter logic [TAUS_W-1:0] SEED_B2 = 32'h0BAD_F00D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              seed_we,
    input  logic [2:0]        seed_sel,
    input  logic [TAUS_W-1:0] seed_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [U0_W-1:0]   u0,
    output logic [U1_W-1:0]   u1
);

    logic              w_adv;
    logic              w_we_a;
    logic              w_we_b;
    logic [1:0]        w_sel_b;
    logic [TAUS_W-1:0] w_word_a;
    logic [TAUS_W-1:0] w_word_b;
    logic [U0_W-1:0]   w_u0_raw;
    logic [U0_W-1:0]   w_u0;
    logic              r_valid;
    logic [U0_W-1:0]   r_u0;
    logic [U1_W-1:0]   r_u1;

    assign w_adv  = en & ~seed_we & (~r_valid | out_ready);
    assign w_we_a = seed_we & (seed_sel < 3'd3);
    assign w_we_b = seed_we & (seed_sel >= 3'd3) & (seed_sel <= 3'd5);

    // Map seed_sel 3..5 onto component index 0..2 of generator B.
    always_comb begin
        w_sel_b = 2'd3;
        case (seed_sel)
            3'd3:    w_sel_b = 2'd0;
            3'd4:    w_sel_b = 2'd1;
            3'd5:    w_sel_b = 2'd2;
            default: w_sel_b = 2'd3;
        endcase
    end

    taus88_core #(
        .SEED0(SEED_A0),
        .SEED1(SEED_A1),
        .SEED2(SEED_A2)
    ) u_gen_a (
        .clk   (clk),
        .rst   (rst),
        .i_adv (w_adv),
        .i_we  (w_we_a),
        .i_sel (seed_sel[1:0]),
        .i_data(seed_data),
        .o_word(w_word_a)
    );

    taus88_core #(
        .SEED0(SEED_B0),
        .SEED1(SEED_B1),
        .SEED2(SEED_B2)
    ) u_gen_b (
        .clk   (clk),
        .rst   (rst),
        .i_adv (w_adv),
        .i_we  (w_we_b),
        .i_sel (w_sel_b),
        .i_data(seed_data),
        .o_word(w_word_b)
    );

    assign w_u0_raw = {w_word_a, w_word_b[TAUS_W-1:U1_W]};

`ifdef URNG_ZERO_GUARD_EN
    // Keeps ln(u0) finite and the downstream LZD valid asserted.
    assign w_u0 = (w_u0_raw == 48'h0) ? 48'h0000_0000_0001 : w_u0_raw;
`else
    assign w_u0 = w_u0_raw;
`endif

    // Output register and handshake; a seed write drops any pending sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_u0    <= 48'h0;
            r_u1    <= 16'h0;
        end else if (seed_we) begin
            r_valid <= 1'b0;
        end else if (w_adv) begin
            r_valid <= 1'b1;
            r_u0    <= w_u0;
            r_u1    <= w_word_b[U1_W-1:0];
        end else if (r_valid & out_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign out_valid = r_valid;
    assign u0        = r_u0;
    assign u1        = r_u1;

endmodule

// File: tb/tb_taus_urng_48_16.sv
// Scoreboard bench for taus_urng_48_16 against a 64-bit-word taus88 reference model.
module tb_taus_urng_48_16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        seed_we = 1'b0;
    logic [2:0]  seed_sel = 3'd0;
    logic [31:0] seed_data = 32'd0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [47:0] u0;
    logic [15:0] u1;

    int total = 0;
    int bad = 0;

    logic [63:0] exp_q[$];
    logic [31:0] ms[6];
    logic        exp_valid = 1'b0;
    logic        exp_zero = 1'b1;
    logic        nxt_valid = 1'b0;
    logic        nxt_zero = 1'b1;
    logic        flush = 1'b0;
    logic        chk_on = 1'b0;
    logic        prev_rst = 1'b0;

    taus_urng_48_16 dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .seed_we  (seed_we),
        .seed_sel (seed_sel),
        .seed_data(seed_data),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .u0       (u0),
        .u1       (u1)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] san_of(input int c);
        case (c)
            0:       return 32'd2;
            1:       return 32'd8;
            default: return 32'd16;
        endcase
    endfunction

    function automatic logic [31:0] ref_step(input logic [31:0] s, input int c);
        int q, sh, k;
        logic [31:0] m;
        case (c)
            0:       begin q = 13; sh = 19; k = 12; m = 32'hFFFF_FFFE; end
            1:       begin q = 2;  sh = 25; k = 4;  m = 32'hFFFF_FFF8; end
            default: begin q = 3;  sh = 11; k = 17; m = 32'hFFFF_FFF0; end
        endcase
        return ((s & m) << k) ^ (((s << q) ^ s) >> sh);
    endfunction

    task automatic model_reset();
        ms[0] = 32'h0000_3039 | 32'd2;
        ms[1] = 32'h0001_E240 | 32'd8;
        ms[2] = 32'h0009_6B43 | 32'd16;
        ms[3] = 32'h1234_5678 | 32'd2;
        ms[4] = 32'h9ABC_DEF0 | 32'd8;
        ms[5] = 32'h0BAD_F00D | 32'd16;
    endtask

    // Step all six components; sample is {wordA, wordB}, u0 = top 48, u1 = low 16.
    task automatic model_next(output logic [63:0] smp);
        logic [31:0] wa, wb;
        for (int i = 0; i < 6; i++) ms[i] = ref_step(ms[i], i % 3);
        wa = ms[0] ^ ms[1] ^ ms[2];
        wb = ms[3] ^ ms[4] ^ ms[5];
        smp = {wa, wb};
    endtask

    task automatic step(input logic r, input logic e, input logic w,
                        input logic [2:0] sel, input logic [31:0] d, input logic rdy);
        logic [63:0] smp;
        @(posedge clk);
        #1;
        if (prev_rst) chk_on = 1'b1;
        if (flush) begin
            exp_q.delete();
            flush = 1'b0;
        end
        exp_valid = nxt_valid;
        exp_zero  = nxt_zero;
        rst = r; en = e; seed_we = w; seed_sel = sel; seed_data = d; out_ready = rdy;
        prev_rst = r;
        if (r) begin
            model_reset();
            nxt_valid = 1'b0;
            nxt_zero  = 1'b1;
            flush     = 1'b1;
        end else if (w) begin
            if (sel <= 3'd5) ms[sel] = d | san_of(int'(sel) % 3);
            nxt_valid = 1'b0;
            flush     = 1'b1;
        end else if (e && (!exp_valid || rdy)) begin
            model_next(smp);
            exp_q.push_back(smp);
            nxt_valid = 1'b1;
            nxt_zero  = 1'b0;
        end else if (exp_valid && rdy) begin
            nxt_valid = 1'b0;
        end
    endtask

    // Monitor: checks the presented sample every cycle, pops it when consumed.
    always @(negedge clk) begin
        if (chk_on) begin
            total++;
            if (out_valid !== exp_valid) begin
                bad++;
                $display("FAIL valid t=%0t got=%b want=%b", $time, out_valid, exp_valid);
            end
            if (exp_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL queue_empty t=%0t got u0=%h u1=%h", $time, u0, u1);
                end else begin
                    if ({u0, u1} !== exp_q[0]) begin
                        bad++;
                        $display("FAIL sample t=%0t got=%h want=%h", $time, {u0, u1}, exp_q[0]);
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else if (exp_zero) begin
                total++;
                if ({u0, u1} !== 64'd0) begin
                    bad++;
                    $display("FAIL reset_out t=%0t got=%h want=0", $time, {u0, u1});
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
        repeat (1000) step(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 1'b1);
        repeat (5) step(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 1'b0);
        repeat (20) step(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
        repeat (300) step(1'b0, ($urandom % 4) != 0, 1'b0, 3'd0, 32'd0, ($urandom % 3) != 0);
        step(1'b0, 1'b1, 1'b1, 3'd0, 32'd0, 1'b0);
        repeat (100) step(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 3'd7, 32'hDEAD_BEEF, 1'b1);
        repeat (50) step(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 3'd6, 32'h0, 1'b0);
        repeat (10) step(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            if (($urandom % 30) == 0)
                step(1'b0, 1'b1, 1'b1, 3'($urandom % 8), $urandom, $urandom % 2 == 1);
            else
                step(1'b0, ($urandom % 4) != 0, 1'b0, 3'd0, 32'd0, ($urandom % 3) != 0);
        end
        repeat (10) step(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 3'd1, 32'h5555_5555, 1'b1);
        repeat (100) step(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
